// File: rtl/ws2812b_driver_if.sv
// Frame request bus between the mode machine and the WS2812B serializer.
// The mode machine owns go/regVal; the serializer reports busy/done.
interface ws2812b_driver_if #(
    parameter int NUM_LEDS = 8
);
    logic                    go;
    logic [12*NUM_LEDS-1:0]  regVal;
    logic                    busy;
    logic                    done;

    modport master (output go, output regVal, input busy, input done);
    modport slave  (input go, input regVal, output busy, output done);
endinterface

// File: rtl/ws2812b_driver.sv
// Serializes a 12-bit-per-LED frame into the WS2812B single-wire protocol,
// expanding each 4-bit channel to {n, 4'b0000}, G/R/B order, MSB first.
//
// state | meaning
// IDLE  | line low, waiting for go; captures regVal into the shadow register
// SEND  | serializing 24*NUM_LEDS bits, CLKS_BIT cycles each
// LATCH | line held low CLKS_LATCH cycles so the strip latches the frame
module ws2812b_driver #(
    parameter int CLKS_T0H   = 40,
    parameter int CLKS_T1H   = 80,
    parameter int CLKS_BIT   = 125,
    parameter int CLKS_LATCH = 5000,
    parameter int NUM_LEDS   = 8
) (
    input  logic                clk,
    input  logic                reset,
    ws2812b_driver_if.slave     ctrl,
    output logic                dataOut
);
    localparam int FRAME_W  = 12 * NUM_LEDS;
    localparam int NUM_BITS = 24 * NUM_LEDS;
    localparam int CNT_W    = (CLKS_BIT > 1)   ? $clog2(CLKS_BIT)   : 1;
    localparam int LAT_W    = (CLKS_LATCH > 1) ? $clog2(CLKS_LATCH) : 1;
    localparam int IDX_W    = (NUM_BITS > 1)   ? $clog2(NUM_BITS)   : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_BIT - 1);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(CLKS_T0H);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(CLKS_T1H);
    localparam logic [LAT_W-1:0] LATCH_LOAD = LAT_W'(CLKS_LATCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]         state;
    logic [FRAME_W-1:0] shadow;
    logic [CNT_W-1:0]   bitCnt;
    logic [IDX_W-1:0]   bitIdx;
    logic [LAT_W-1:0]   latchCnt;
    logic               doneReg;

    logic [3:0]         nib;
    logic [1:0]         nibSel;
    logic               curBit;
    logic [CNT_W-1:0]   thCur;

    // The frame is divisible into whole bytes, so bitIdx[2:0] is the position
    // within the current byte: bits 0..3 carry the nibble, 4..7 are padding.
    // The shadow shifts one nibble per byte, so the live nibble is always on top.
    assign nib    = shadow[FRAME_W-1 -: 4];
    assign nibSel = ~bitIdx[1:0];
    assign curBit = ~bitIdx[2] & nib[nibSel];
    assign thCur  = curBit ? T1H_C : T0H_C;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shadow   <= '0;
            bitCnt   <= '0;
            bitIdx   <= '0;
            latchCnt <= '0;
            dataOut  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    dataOut <= 1'b0;
                    if (ctrl.go) begin
                        shadow <= ctrl.regVal;
                        bitCnt <= '0;
                        bitIdx <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    // Output lags the counter by one flop so the pin is glitch-free.
                    dataOut <= (bitCnt < thCur);
                    if (bitCnt == BIT_LAST) begin
                        bitCnt <= '0;
                        if (bitIdx[2:0] == 3'd7) begin
                            shadow <= {shadow[FRAME_W-5:0], 4'b0000};
                        end
                        if (bitIdx == IDX_LAST) begin
                            latchCnt <= LATCH_LOAD;
                            state    <= LATCH;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                LATCH: begin
                    dataOut <= 1'b0;
                    if (latchCnt == '0) begin
                        doneReg <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        latchCnt <= latchCnt - 1'b1;
                    end
                end
                default: begin
                    dataOut <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ctrl.busy = (state != IDLE);
    assign ctrl.done = doneReg;
endmodule

// File: tb/tb_ws2812b_driver.sv
// Directed bench for ws2812b_driver: decodes pulses on dataOut and compares
// decoded LED words and frame timing against hand-computed values.
module tb_ws2812b_driver;
    localparam int T0H   = 40;
    localparam int T1H   = 80;
    localparam int TBIT  = 125;
    localparam int TLAT  = 5000;
    localparam int NBITS = 192;
    localparam int NV    = 10;

    typedef struct {
        string       name;
        int          phase;
        logic [95:0] frameVal;
        int          bitOff;
        logic [23:0] expWord;
    } FrameVec;

    logic clk = 1'b0;
    logic reset;
    logic dataOut;
    ws2812b_driver_if #(.NUM_LEDS(8)) ctrl();

    ws2812b_driver dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl    (ctrl),
        .dataOut (dataOut)
    );

    initial forever #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic bitsQ[$];
    int   hiQ[$];
    int   riseQ[$];
    int   busyLenQ[$];
    int   badPulse = 0;
    int   doneCount = 0;
    int   doneCyc = 0;
    int   hiLen = 0;
    int   busyRun = 0;
    logic prevD = 1'b0;
    logic prevBusy = 1'b0;
    FrameVec vecs[NV];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pulse decoder: a high run of T1H decodes as 1, anything else as 0.
    initial forever begin
        @(negedge clk);
        if (dataOut) begin
            if (!prevD) begin
                riseQ.push_back(cyc);
                hiLen = 0;
            end
            hiLen++;
        end else if (prevD) begin
            hiQ.push_back(hiLen);
            bitsQ.push_back(hiLen == T1H);
            if (hiLen != T0H && hiLen != T1H) badPulse++;
        end
        if (ctrl.busy) busyRun++;
        else if (prevBusy) begin
            busyLenQ.push_back(busyRun);
            busyRun = 0;
        end
        if (ctrl.done) begin
            doneCount++;
            doneCyc = cyc;
        end
        prevD    = dataOut;
        prevBusy = ctrl.busy;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearMon();
        bitsQ.delete();
        hiQ.delete();
        riseQ.delete();
        busyLenQ.delete();
        badPulse  = 0;
        doneCount = 0;
        busyRun   = 0;
    endtask

    task automatic waitBits(int n, int budget, string name);
        int t = 0;
        while (bitsQ.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (bitsQ.size() < n) begin
            fails++;
            $display("FAIL %s: got %0d bits, needed %0d", name, bitsQ.size(), n);
        end
    endtask

    task automatic waitDone(int n, int budget, string name);
        int t = 0;
        while (doneCount < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (doneCount < n) begin
            fails++;
            $display("FAIL %s: got %0d done pulses, needed %0d", name, doneCount, n);
        end
    endtask

    function automatic logic [23:0] getWord(int off);
        logic [23:0] w;
        w = 'x;
        if (bitsQ.size() >= off + 24) begin
            for (int b = 0; b < 24; b++) w[23-b] = bitsQ[off+b];
        end
        return w;
    endfunction

    task automatic checkPhase(int ph);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == ph) check(vecs[i].name, 64'(getWord(vecs[i].bitOff)), 64'(vecs[i].expWord));
        end
    endtask

    initial begin
        int t;
        int badHi;
        int badPer;

        vecs[0] = '{"bee_led0",  1, 96'hBEE_DAD_BEE_DAD_BEE_DAD_BEE_DAD, 0,   24'hB0E0E0};
        vecs[1] = '{"bee_led1",  1, 96'hBEE_DAD_BEE_DAD_BEE_DAD_BEE_DAD, 24,  24'hD0A0D0};
        vecs[2] = '{"cab_led0",  2, 96'hCAB_FAD_CAB_FAD_CAB_FAD_CAB_FAD, 0,   24'hC0A0B0};
        vecs[3] = '{"cab_led1",  2, 96'hCAB_FAD_CAB_FAD_CAB_FAD_CAB_FAD, 24,  24'hF0A0D0};
        vecs[4] = '{"cab_led6",  2, 96'hCAB_FAD_CAB_FAD_CAB_FAD_CAB_FAD, 144, 24'hC0A0B0};
        vecs[5] = '{"cab_led7",  2, 96'hCAB_FAD_CAB_FAD_CAB_FAD_CAB_FAD, 168, 24'hF0A0D0};
        vecs[6] = '{"fff_led0",  2, {96{1'b1}},                          192, 24'hF0F0F0};
        vecs[7] = '{"fff_led1",  2, {96{1'b1}},                          216, 24'hF0F0F0};
        vecs[8] = '{"zero_led0", 3, 96'h0,                               0,   24'h000000};
        vecs[9] = '{"zero_led7", 3, 96'h0,                               168, 24'h000000};

        // Reset held with go high: nothing may start.
        reset = 1'b1;
        ctrl.go = 1'b1;
        ctrl.regVal = vecs[0].frameVal;
        repeat (3) begin
            @(negedge clk);
            check("reset_idle", 64'({dataOut, ctrl.busy, ctrl.done}), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("start_busy_first", 64'({ctrl.busy, dataOut}), 64'b10);
        ctrl.go = 1'b0;
        @(negedge clk);
        check("start_data_rise", 64'(dataOut), 64'd1);

        // Data mapping, then reset while bit 100 is high.
        waitBits(48, 7000, "map_bits");
        checkPhase(1);
        check("map_pulse_widths", 64'(badPulse), 64'd0);
        t = 0;
        while (!(riseQ.size() >= 101 && dataOut) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_reached_bit100", 64'(riseQ.size() >= 101 && dataOut), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 64'({dataOut, ctrl.busy}), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_no_done", 64'(doneCount), 64'd0);
        clearMon();

        // Full frame with go held, regVal swapped at bit 50; refresh follows.
        ctrl.regVal = vecs[2].frameVal;
        ctrl.go = 1'b1;
        waitBits(50, 7000, "cab_bit50");
        ctrl.regVal = vecs[6].frameVal;
        waitDone(1, 30000, "cab_done");
        t = 0;
        while (riseQ.size() < 193 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("refresh_spacing", 64'(riseQ.size() >= 193 ? riseQ[192] - riseQ[0] : -1), 64'd29001);
        waitBits(240, 7000, "fff_bits");
        checkPhase(2);
        check("refresh_done_once", 64'(doneCount), 64'd1);
        check("refresh_busy_len", 64'(busyLenQ.size() >= 1 ? busyLenQ[0] : -1), 64'(NBITS * TBIT + TLAT));
        check("cab_pulse_widths", 64'(badPulse), 64'd0);
        ctrl.go = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clearMon();

        // All-zero frame from a single-cycle go pulse.
        ctrl.regVal = vecs[8].frameVal;
        ctrl.go = 1'b1;
        @(negedge clk);
        ctrl.go = 1'b0;
        waitDone(1, 30000, "zero_done");
        repeat (20) @(negedge clk);
        check("zero_bit_count", 64'(bitsQ.size()), 64'(NBITS));
        badHi = 0;
        foreach (hiQ[i]) if (hiQ[i] != T0H) badHi++;
        check("zero_high_40", 64'(badHi), 64'd0);
        badPer = 0;
        for (int i = 0; i + 1 < riseQ.size(); i++) if (riseQ[i+1] - riseQ[i] != TBIT) badPer++;
        check("zero_period_125", 64'(badPer), 64'd0);
        check("zero_latch_len", 64'(riseQ.size() == NBITS ? doneCyc - riseQ[NBITS-1] : -1), 64'(TBIT + TLAT - 1));
        check("zero_frame_len", 64'(riseQ.size() >= 1 ? doneCyc - riseQ[0] : -1), 64'(NBITS * TBIT + TLAT - 1));
        check("zero_busy_len", 64'(busyLenQ.size() == 1 ? busyLenQ[0] : -1), 64'(NBITS * TBIT + TLAT));
        check("zero_done_once", 64'(doneCount), 64'd1);
        checkPhase(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ws2812b_driver.md
# ws2812b_driver

Serializes the 96-bit LED frame produced by the mode machine into the single-wire WS2812B protocol for a strip of 8 LEDs. It sits directly downstream of the mode machine: it consumes that block's `go` and `regVal` outputs, expands each 4-bit color channel to the 8-bit WS2812B format, and drives the strip data pin on the BASYS 3 board. Timing constants are in cycles of the 100 MHz system clock.

## Interface
- `CLKS_T0H`, default 40: high time of a `0` bit, in cycles (0.40 µs).
- `CLKS_T1H`, default 80: high time of a `1` bit, in cycles (0.80 µs).
- `CLKS_BIT`, default 125: total bit period, in cycles (1.25 µs).
- `CLKS_LATCH`, default 5000: low time after the frame that latches the strip, in cycles (50 µs).
- `NUM_LEDS`, default 8: number of LEDs; `regVal` width is 12·NUM_LEDS.
- `clk`, input, 1 bit: 100 MHz system clock. All logic is on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `go`, input, 1 bit: frame request from the mode machine. Level-sensitive and sampled only in IDLE.
- `regVal`, input, 96 bits: frame data, 12 bits per LED.
- `dataOut`, output, 1 bit: WS2812B data line. Registered.
- `busy`, output, 1 bit: high while a frame or latch is in progress.
- `done`, output, 1 bit: one-cycle pulse when a frame (including its latch) completes.

## Operation
- **Reset values:** `dataOut`=0, `busy`=0, `done`=0. State is IDLE. The shadow register and all counters are 0.
- **States:** IDLE → SEND → LATCH → IDLE.
- **IDLE:**
  - `dataOut`=0 and `busy`=0.
  - If `go`=1 at an edge, that edge captures `regVal` into a 96-bit shadow register, clears the bit index and cycle counter, and moves to SEND.
- **Frame data mapping:**
  - LED *i* word = `regVal[95-12i : 84-12i]`, so LED0 is `regVal[95:84]` and is sent first.
  - Each word is `{G[3:0], R[3:0], B[3:0]}` in bits [11:8], [7:4], [3:0].
  - Each nibble `n` expands to the byte `{n, 4'b0000}`.
  - Channel order on the wire is G, R, B, MSB first. That gives 24 bits per LED and 24·NUM_LEDS = 192 bits per frame.
- **SEND:**
  - For each bit, a cycle counter runs 0..CLKS_BIT-1.
  - `dataOut`=1 while counter < T_H, where T_H = CLKS_T1H for a `1` bit and CLKS_T0H for a `0` bit. Otherwise `dataOut`=0.
  - At counter = CLKS_BIT-1 the bit index increments.
  - After the last bit (index 191) completes, the state moves to LATCH.
- **LATCH:**
  - `dataOut`=0 for CLKS_LATCH cycles, then the state returns to IDLE.
  - `done` is asserted for exactly the first IDLE cycle.
- **`busy`:** high in SEND and LATCH, low in IDLE.
- **`go` during SEND/LATCH:** ignored. No queuing.
- **`go` held high:** restarts a new frame on the first IDLE cycle. This gives continuous refresh.
- **`regVal` changes mid-frame:** no effect. Only the shadow register is serialized. New data appears on the next frame.
- **`reset` mid-frame:** on the next edge, `dataOut`=0, the state is IDLE, and counters are cleared. `done` is not pulsed. The partial frame is abandoned.
- **Simultaneous `reset` and `go`:** `reset` wins. The state stays IDLE.

## Timing
- **Start latency:** `go` is sampled at edge k. `dataOut` rises at edge k+1, the first cycle of bit 0.
- **`0` bit:** 40 cycles high, then 85 cycles low.
- **`1` bit:** 80 cycles high, then 45 cycles low.
- **Frame length:** SEND lasts 192·125 = 24000 cycles and LATCH lasts 5000 cycles. `busy` is high for 29000 consecutive cycles.
- **`done`:**
  - Pulses on the cycle after the last LATCH cycle.
  - It coincides with the first IDLE cycle, where `go` may be sampled again.
  - With `go` held high, consecutive frames start exactly 29001 cycles apart.
- **Output quality:** `dataOut` comes directly from a flop, so there are no combinational glitches.

## Test plan
- **Reset:**
  - Stimulus: hold `reset`=1 for 3 cycles with `go`=1.
  - Required: `dataOut`=0, `busy`=0, `done`=0 throughout. The first frame starts one cycle after `reset` is released.
- **All-zero frame:**
  - Stimulus: `regVal`=96'h0, then pulse `go` for 1 cycle.
  - Required: 192 pulses, each 40 high and 85 low. Then 5000 low cycles. `done` is high for 1 cycle, and `busy` is high for exactly 29000 cycles.
- **Data mapping:**
  - Stimulus: `regVal`=96'hBEE_DAD_BEE_DAD_BEE_DAD_BEE_DAD.
  - Required: the first 24 decoded bits are 1011_0000 1110_0000 1110_0000, and the next 24 are 1101_0000 1010_0000 1101_0000. Every decoded `1` pulse is exactly 80 cycles high.
- **`regVal` change mid-frame:**
  - Stimulus: start a frame with 96'hCAB_FAD…, then switch `regVal` to all-F at bit 50.
  - Required: the full CABFAD pattern is still sent. The next frame carries F0F0F0 per LED.
- **Continuous refresh:**
  - Stimulus: hold `go`=1 across two frames.
  - Required: the rising edge of bit 0 of frame 2 comes exactly 29001 cycles after that of frame 1. `done` fires once per frame.
- **Reset mid-frame:**
  - Stimulus: assert `reset` at bit 100 while `dataOut` is high.
  - Required: `dataOut`=0 and `busy`=0 on the next cycle, with no `done` pulse. A subsequent `go` produces a complete frame starting from bit 0.
